// File: rtl/lc_osc_freq_counter.sv
// lc_osc_freq_counter: counts synchronized oscillator rising edges over a
// programmable 2^(GATE_MIN_LOG2+gate_sel) clk gate window. Rev 1.0.
`default_nettype none

module lc_osc_freq_counter #(
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int GATE_MIN_LOG2 = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  input  logic             continuous,
  input  logic [2:0]       gate_sel,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             overflow
);

  localparam int GW = GATE_MIN_LOG2 + 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [2:0]             gsel_q;
  logic [GW-1:0]          gate_cnt_q;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       result_q;
  logic                   result_valid_q;
  logic                   busy_q;
  logic                   overflow_q;

  logic                   rise;
  logic [GW-1:0]          gate_last;

  assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign gate_last = (GW'(1) << (GATE_MIN_LOG2 + 32'(gsel_q))) - GW'(1);

  // Edge counter saturates at all-ones and flags the window as overflowed.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    if (state_q == GATE && rise) begin
      if (&edge_cnt_q) ovf_d = 1'b1;
      else             edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sync_q         <= '0;
      prev_q         <= 1'b0;
      gsel_q         <= '0;
      gate_cnt_q     <= '0;
      edge_cnt_q     <= '0;
      ovf_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      sync_q         <= {sync_q[SYNC_STAGES-2:0], osc_in};
      prev_q         <= sync_q[SYNC_STAGES-1];
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            gsel_q     <= gate_sel;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= GATE;
          end
        end
        GATE: begin
          edge_cnt_q <= edge_cnt_d;
          ovf_q      <= ovf_d;
          // Outputs are registered, so publish on the edge entering DONE.
          if (gate_cnt_q == gate_last) begin
            result_q       <= edge_cnt_d;
            overflow_q     <= ovf_d;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end else begin
            gate_cnt_q <= gate_cnt_q + GW'(1);
          end
        end
        DONE: begin
          if (continuous) begin
            gsel_q     <= gate_sel;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            state_q    <= GATE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_lc_osc_freq_counter.sv
// Testbench for lc_osc_freq_counter: directed steps with a result scoreboard.
`default_nettype none

module tb_lc_osc_freq_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        osc_in;
  logic        start;
  logic        continuous;
  logic [2:0]  gate_sel;
  logic [15:0] result;
  logic        result_valid, busy, overflow;
  logic [7:0]  result8;
  logic        result_valid8, busy8, overflow8;

  int cyc = 0;
  int osc_per = 0;
  int osc_ph = 0;
  int busy_cnt = 0;
  int total = 0;
  int passed = 0;

  typedef struct {
    int cyc;
    int lo;
    int hi;
    int ovf;
    bit c8;
    int v8;
    int ovf8;
  } exp_t;
  exp_t sb[$];

  lc_osc_freq_counter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start),
    .continuous(continuous), .gate_sel(gate_sel), .result(result),
    .result_valid(result_valid), .busy(busy), .overflow(overflow)
  );

  lc_osc_freq_counter #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start),
    .continuous(continuous), .gate_sel(gate_sel), .result(result8),
    .result_valid(result_valid8), .busy(busy8), .overflow(overflow8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert ((obs >= lo && obs <= hi) === 1'b1) passed++;
    else $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
  endtask

  // Scoreboard consumer: every result_valid must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (result_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk_rng("result", int'(result), e.lo, e.hi);
          chk("overflow", overflow, e.ovf);
          chk("valid8_align", result_valid8, 1);
          if (e.c8) begin
            chk("result8", result8, e.v8);
            chk("overflow8", overflow8, e.ovf8);
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [2:0] gs, output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    gate_sel = gs;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int idle_cyc);
    bit seen = 0;
    idle_cyc = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1;
        idle_cyc = cyc;
      end
    end
    if (!seen) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int t0, ic;
    rst = 1'b1; osc_in = 1'b0; start = 1'b0; continuous = 1'b0; gate_sel = 3'd0;
    fork
      forever begin
        @(posedge clk); #1;
        if (osc_per == 0) osc_in = 1'b0;
        else begin
          osc_ph = (osc_ph + 1) % osc_per;
          osc_in = (osc_ph < osc_per / 2);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Single shot, period 10, G=256
    osc_per = 10;
    repeat (20) @(posedge clk);
    busy_cnt = 0;
    pulse_start(3'd0, t0);
    sb.push_back('{t0 + 257, 25, 26, 0, 1'b0, 0, 0});
    wait_idle(400, ic);
    chk("single_busy_len", busy_cnt, 257);
    chk("single_idle_cyc", ic, t0 + 258);

    // Zero input, G=2048
    osc_per = 0;
    repeat (20) @(posedge clk);
    pulse_start(3'd3, t0);
    sb.push_back('{t0 + 2049, 0, 0, 0, 1'b1, 0, 0});
    wait_idle(2200, ic);

    // Saturation on the 8-bit instance, then recovery
    osc_per = 2;
    repeat (20) @(posedge clk);
    pulse_start(3'd1, t0);
    sb.push_back('{t0 + 513, 256, 256, 0, 1'b1, 255, 1});
    wait_idle(700, ic);
    osc_per = 8;
    repeat (20) @(posedge clk);
    pulse_start(3'd1, t0);
    sb.push_back('{t0 + 513, 64, 64, 0, 1'b1, 64, 0});
    wait_idle(700, ic);

    // Continuous, period 8; drop continuous in the fourth window
    repeat (20) @(posedge clk);
    continuous = 1'b1;
    pulse_start(3'd0, t0);
    for (int k = 1; k <= 4; k++) sb.push_back('{t0 + 257 * k, 31, 33, 0, 1'b0, 0, 0});
    repeat (257 * 3 + 100) @(posedge clk);
    #1 continuous = 1'b0;
    wait_idle(400, ic);
    chk("cont_idle_cyc", ic, t0 + 4 * 257 + 1);

    // start and gate_sel changes during GATE are ignored
    osc_per = 10;
    repeat (20) @(posedge clk);
    pulse_start(3'd0, t0);
    sb.push_back('{t0 + 257, 25, 26, 0, 1'b0, 0, 0});
    repeat (50) @(posedge clk);
    #1 start = 1'b1; gate_sel = 3'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(400, ic);
    chk("ignored_idle_cyc", ic, t0 + 258);
    repeat (300) @(posedge clk);
    chk("ignored_still_idle", busy, 0);
    gate_sel = 3'd0;

    // Asynchronous reset at cycle 100 of a window
    pulse_start(3'd0, t0);
    repeat (99) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_result", result, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_result8", result8, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (300) @(posedge clk);
    chk("post_rst_idle", busy, 0);
    pulse_start(3'd0, t0);
    sb.push_back('{t0 + 257, 25, 26, 0, 1'b0, 0, 0});
    wait_idle(400, ic);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
